param_universal_reg: RTL and testbench
======================================

// Module: param_universal_reg
// PURPOSE
//  Parametrised WIDTH-bit register: hold, parallel load, shift, rotate, up/down count.
//  Keeps the flip-flop control set: async clear, sync clear and clock enable.
//  Drop-in storage/shift/count element for datapath and control blocks in this design.
// PARAMETERS
//  WIDTH      8    register width in bits (>=2)
//  RESET_VAL  0    value loaded by aReset and by sync reset (WIDTH bits)
// PORTS
//  clk      in   1      clock; all state updates on rising edge
//  aReset   in   1      async reset, active-low; Q<=RESET_VAL immediately
//  reset    in   1      sync reset, active-low; Q<=RESET_VAL at next rising clk
//  enable   in   1      clock enable, active-high; 0 = hold
//  mode     in   3      operation select (see BEHAVIOUR)
//  D        in   WIDTH  parallel load data
//  serInL   in   1      serial in, enters at LSB on shift-left
//  serInR   in   1      serial in, enters at MSB on shift-right
//  Q        out  WIDTH  register contents
//  Qbar     out  WIDTH  ~Q, combinational from Q
//  serOutL  out  1      Q[WIDTH-1] (bit shifted out on shift-left)
//  serOutR  out  1      Q[0] (bit shifted out on shift-right)
//  tc       out  1      terminal-count pulse; only with PUR_TC_EN
// BEHAVIOUR
//  Priority per edge: aReset=0 > reset=0 > enable=0 > mode.
//  aReset=0: Q=RESET_VAL, Qbar=~RESET_VAL, tc=0 asynchronously; held while low.
//  aReset release: first update on the first rising clk edge with aReset=1.
//  reset=0 at an edge: Q<=RESET_VAL, tc<=0; enable and mode ignored.
//  enable=0 (resets inactive): Q holds; tc<=0.
//  mode (enable=1), one-cycle latency, result visible after the edge:
//   000 HOLD  Q<=Q
//   001 LOAD  Q<=D
//   010 SHL   Q<={Q[WIDTH-2:0],serInL}
//   011 SHR   Q<={serInR,Q[WIDTH-1:1]}
//   100 ROL   Q<={Q[WIDTH-2:0],Q[WIDTH-1]}
//   101 ROR   Q<={Q[0],Q[WIDTH-1:1]}
//   110 INC   Q<=Q+1 mod 2^WIDTH; all-ones wraps to 0
//   111 DEC   Q<=Q-1 mod 2^WIDTH; 0 wraps to all-ones
//  Arithmetic is unsigned, WIDTH bits; carry/borrow is discarded.
//  serOutL/serOutR/Qbar are combinational from Q; no extra latency.
//  No state machine beyond Q; no hidden state besides tc.
// CONFIGURATION
//  PUR_TC_EN defined: registered output tc.
//   tc<=1 for the edge where INC takes Q from all-ones to 0, or DEC takes Q from 0 to all-ones.
//   Otherwise tc<=0; reset/hold clear it, so tc is a single-cycle pulse.
//  PUR_TC_EN undefined: port tc and its flop are absent; all else identical.
// STRUCTURE
//  Package pur_pkg: typedef enum logic[2:0] pur_mode_e
//   {PUR_HOLD,PUR_LOAD,PUR_SHL,PUR_SHR,PUR_ROL,PUR_ROR,PUR_INC,PUR_DEC}
//   plus PUR_MODE_W=3.
//  Sub-module pur_next_state: combinational (Q,D,mode,serInL,serInR)->nextQ[,wrap].
//  Top holds the state flops, control priority and tc.
// TESTING (WIDTH=8, RESET_VAL=8'h00)
//  aReset=0 mid-cycle with Q=8'hA5 -> Q=00, Qbar=FF before the next edge; tc=0.
//  LOAD D=8'h81, then SHL serInL=1 -> 8'h03, serOutL was 1; then SHR serInR=0 -> 8'h01.
//  Q=8'h81: ROL -> 8'h03; ROR from 8'h03 -> 8'h81; enable=0 for 3 edges -> stays 8'h81.
//  LOAD 8'hFE, INC x2 -> FF then 00; with PUR_TC_EN, tc=1 only after the second edge.
//  LOAD 8'h00, DEC -> 8'hFF with tc=1.
//  reset=0 together with mode=LOAD, D=8'h55, enable=1 -> Q=00.
//  reset=0 with enable=0 also clears Q.

Source files
------------

// File: rtl/pur_pkg.sv
// Shared types for the universal register.
// Mode encoding and width of the mode bus.
package pur_pkg;

  localparam int PUR_MODE_W = 3;

  typedef enum logic [PUR_MODE_W-1:0] {
    PUR_HOLD,
    PUR_LOAD,
    PUR_SHL,
    PUR_SHR,
    PUR_ROL,
    PUR_ROR,
    PUR_INC,
    PUR_DEC
  } pur_mode_e;

endpackage

// File: rtl/pur_next_state.sv
// Next-value datapath for the universal register.
// Optional wrap flag under PUR_TC_EN.
module pur_next_state
  import pur_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  pur_mode_e        mode,
  input  logic             serInL,
  input  logic             serInR,
`ifdef PUR_TC_EN
  output logic             wrap,
`endif
  output logic [WIDTH-1:0] nextQ
);

  // Select the candidate value for the selected operation.
  always_comb begin
    nextQ = q;
    unique case (mode)
      PUR_HOLD: nextQ = q;
      PUR_LOAD: nextQ = d;
      PUR_SHL:  nextQ = {q[WIDTH-2:0], serInL};
      PUR_SHR:  nextQ = {serInR, q[WIDTH-1:1]};
      PUR_ROL:  nextQ = {q[WIDTH-2:0], q[WIDTH-1]};
      PUR_ROR:  nextQ = {q[0], q[WIDTH-1:1]};
      PUR_INC:  nextQ = q + 1'b1;
      PUR_DEC:  nextQ = q - 1'b1;
      default:  nextQ = q;
    endcase
  end

`ifdef PUR_TC_EN
  // Count wraps past either end of the unsigned range.
  always_comb begin
    wrap = 1'b0;
    if (mode == PUR_INC && (&q))
      wrap = 1'b1;
    else if (mode == PUR_DEC && ~(|q))
      wrap = 1'b1;
  end
`endif

endmodule

// File: rtl/param_universal_reg.sv
// Universal register: hold/load/shift/rotate/count.
// Define PUR_TC_EN to add the terminal-count pulse tc.
module param_universal_reg
  import pur_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             aReset,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             serInL,
  input  logic             serInR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             serOutL,
`ifdef PUR_TC_EN
  output logic             tc,
`endif
  output logic             serOutR
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
`ifdef PUR_TC_EN
  logic             w_wrap;
  logic             r_tc;
`endif

  pur_next_state #(
    .WIDTH (WIDTH)
  ) u_next (
    .q      (r_q),
    .d      (D),
    .mode   (pur_mode_e'(mode)),
    .serInL (serInL),
    .serInR (serInR),
`ifdef PUR_TC_EN
    .wrap   (w_wrap),
`endif
    .nextQ  (w_next)
  );

  // State register: async clear, sync clear, enable.
  always_ff @(posedge clk or negedge aReset) begin
    if (!aReset)
      r_q <= RESET_VAL;
    else if (!reset)
      r_q <= RESET_VAL;
    else if (enable)
      r_q <= w_next;
  end

`ifdef PUR_TC_EN
  // One-cycle pulse on the edge that wraps the count.
  always_ff @(posedge clk or negedge aReset) begin
    if (!aReset)
      r_tc <= 1'b0;
    else if (!reset || !enable)
      r_tc <= 1'b0;
    else
      r_tc <= w_wrap;
  end

  assign tc = r_tc;
`endif

  assign Q       = r_q;
  assign Qbar    = ~r_q;
  assign serOutL = r_q[WIDTH-1];
  assign serOutR = r_q[0];

endmodule

// File: tb/tb_param_universal_reg.sv
// Self-checking bench for param_universal_reg.
// Covers tc when built with PUR_TC_EN.
module tb_param_universal_reg;

  logic       clk = 1'b0;
  logic       aReset = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] D = 8'h00;
  logic       serInL = 1'b0;
  logic       serInR = 1'b0;
  logic [7:0] Q;
  logic [7:0] Qbar;
  logic       serOutL;
  logic       serOutR;
`ifdef PUR_TC_EN
  logic       tc;
`endif

  int n_chk = 0;
  int n_fail = 0;

  int m_q = 0;
  int m_tc = 0;

  param_universal_reg #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .clk     (clk),
    .aReset  (aReset),
    .reset   (reset),
    .enable  (enable),
    .mode    (mode),
    .D       (D),
    .serInL  (serInL),
    .serInR  (serInR),
    .Q       (Q),
    .Qbar    (Qbar),
    .serOutL (serOutL),
`ifdef PUR_TC_EN
    .tc      (tc),
`endif
    .serOutR (serOutR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Model outputs compared on every falling edge.
  always @(negedge clk) begin
    chk("Q", int'(Q), m_q);
    chk("Qbar", int'(Qbar), 255 - m_q);
    chk("serOutL", int'(serOutL), m_q / 128);
    chk("serOutR", int'(serOutR), m_q % 2);
`ifdef PUR_TC_EN
    chk("tc", int'(tc), m_tc);
`endif
  end

  // Apply one edge of stimulus and advance the model.
  task automatic step(input logic en, input logic rs,
                      input logic [2:0] md, input logic [7:0] d,
                      input logic sl, input logic sr);
    int nq;
    enable = en;
    reset  = rs;
    mode   = md;
    D      = d;
    serInL = sl;
    serInR = sr;
    @(posedge clk);
    nq   = m_q;
    m_tc = 0;
    if (!rs) begin
      nq = 0;
    end else if (en) begin
      case (md)
        3'd1: nq = int'(d);
        3'd2: nq = (m_q * 2) % 256 + int'(sl);
        3'd3: nq = m_q / 2 + 128 * int'(sr);
        3'd4: nq = (m_q * 2) % 256 + m_q / 128;
        3'd5: nq = m_q / 2 + 128 * (m_q % 2);
        3'd6: begin
          nq = (m_q + 1) % 256;
          m_tc = (m_q == 255) ? 1 : 0;
        end
        3'd7: begin
          nq = (m_q + 255) % 256;
          m_tc = (m_q == 0) ? 1 : 0;
        end
        default: nq = m_q;
      endcase
    end
    m_q = nq;
    @(negedge clk);
  endtask

  initial begin
    m_q = 0;
    @(negedge clk);
    chk("rst_Q_lit", int'(Q), 8'h00);
    chk("rst_Qbar_lit", int'(Qbar), 8'hFF);
    aReset = 1'b1;

    step(1, 1, 3'd1, 8'hA5, 0, 0);
    chk("load_A5_lit", int'(Q), 8'hA5);
    #3;
    aReset = 1'b0;
    m_q = 0;
    m_tc = 0;
    #1;
    chk("areset_Q_lit", int'(Q), 8'h00);
    chk("areset_Qbar_lit", int'(Qbar), 8'hFF);
`ifdef PUR_TC_EN
    chk("areset_tc_lit", int'(tc), 0);
`endif
    @(negedge clk);
    chk("areset_hold_lit", int'(Q), 8'h00);
    aReset = 1'b1;

    step(1, 1, 3'd1, 8'h81, 0, 0);
    chk("serOutL_pre_shl_lit", int'(serOutL), 1);
    step(1, 1, 3'd2, 8'h00, 1, 0);
    chk("shl_lit", int'(Q), 8'h03);
    step(1, 1, 3'd3, 8'h00, 0, 0);
    chk("shr_lit", int'(Q), 8'h01);

    step(1, 1, 3'd1, 8'h81, 0, 0);
    step(1, 1, 3'd4, 8'h00, 0, 0);
    chk("rol_lit", int'(Q), 8'h03);
    step(1, 1, 3'd5, 8'h00, 0, 0);
    chk("ror_lit", int'(Q), 8'h81);
    for (int i = 0; i < 3; i++)
      step(0, 1, 3'd1, 8'h55, 1, 1);
    chk("en0_hold_lit", int'(Q), 8'h81);

    step(1, 1, 3'd1, 8'hFE, 0, 0);
    step(1, 1, 3'd6, 8'h00, 0, 0);
    chk("inc_ff_lit", int'(Q), 8'hFF);
`ifdef PUR_TC_EN
    chk("inc_tc0_lit", int'(tc), 0);
`endif
    step(1, 1, 3'd6, 8'h00, 0, 0);
    chk("inc_wrap_lit", int'(Q), 8'h00);
`ifdef PUR_TC_EN
    chk("inc_tc1_lit", int'(tc), 1);
`endif
    step(1, 1, 3'd0, 8'h00, 0, 0);
`ifdef PUR_TC_EN
    chk("tc_pulse_lit", int'(tc), 0);
`endif

    step(1, 1, 3'd1, 8'h00, 0, 0);
    step(1, 1, 3'd7, 8'h00, 0, 0);
    chk("dec_wrap_lit", int'(Q), 8'hFF);
`ifdef PUR_TC_EN
    chk("dec_tc1_lit", int'(tc), 1);
`endif

    step(1, 0, 3'd1, 8'h55, 0, 0);
    chk("srst_load_lit", int'(Q), 8'h00);
    step(1, 1, 3'd1, 8'h3C, 0, 0);
    step(0, 0, 3'd1, 8'h3C, 0, 0);
    chk("srst_en0_lit", int'(Q), 8'h00);

    step(1, 1, 3'd3, 8'h00, 0, 1);
    chk("shr_in1_lit", int'(Q), 8'h80);
    step(1, 1, 3'd7, 8'h00, 0, 0);
    chk("dec_7f_lit", int'(Q), 8'h7F);

    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 7) != 0),
           ($urandom_range(0, 15) != 0),
           3'($urandom_range(0, 7)),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
